// File: rtl/lift_car_model.sv
// Lift car and shaft plant model: turns the controller's direction/motion/door
// commands into the floor sensor one-hot, with travel and door timing, and
// latches the first illegal command sequence it sees.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   direction         1 = up, 0 = down
//   motion            1 = drive the car
//   door_open         1 = open door, 0 = close door
//   floor_sense       one-hot current floor, all zero between floors
//   floor_idx         index of the last floor reached
//   arrive            one-cycle pulse when the car reaches a floor
//   door_closed       door counter at zero
//   door_fully_open   door counter at DOOR_CYCLES
//   fault, fault_code sticky first fault (1 DOOR_MOVE, 2 OVERTRAVEL, 3 STALL)
module lift_car_model #(
  parameter int unsigned N_FLOORS      = 8,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned INIT_FLOOR    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        direction,
  input  logic                        motion,
  input  logic                        door_open,
  output logic [N_FLOORS-1:0]         floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] floor_idx,
  output logic                        arrive,
  output logic                        door_closed,
  output logic                        door_fully_open,
  output logic                        fault,
  output logic [1:0]                  fault_code
);

  localparam int unsigned FLOOR_W = $clog2(N_FLOORS);
  localparam int unsigned STEP_W  = $clog2(TRAVEL_CYCLES);
  localparam int unsigned DOOR_W  = $clog2(DOOR_CYCLES + 1);

  localparam logic [FLOOR_W-1:0] FLOOR_TOP  = FLOOR_W'(N_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_INIT = FLOOR_W'(INIT_FLOOR);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_MAX   = DOOR_W'(DOOR_CYCLES);
  localparam logic [N_FLOORS-1:0] ONEHOT_0  = {{(N_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_AT_FLOOR = 1'b0,
    ST_TRAVEL   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'd0,
    FC_DOOR_MOVE  = 2'd1,
    FC_OVERTRAVEL = 2'd2,
    FC_STALL      = 2'd3
  } fault_code_e;

  state_e              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_idx_q, floor_idx_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                dir_q, dir_d;
  logic [DOOR_W-1:0]   door_cnt_q, door_cnt_d;
  logic [N_FLOORS-1:0] floor_sense_q, floor_sense_d;
  logic                arrive_q, arrive_d;
  logic                door_closed_q, door_closed_d;
  logic                door_fully_open_q, door_fully_open_d;
  logic                fault_q, fault_d;
  fault_code_e         fault_code_q, fault_code_d;

  logic door_move_c, overtravel_c, stall_c, at_limit_c;

  // Next-state: car motion, door actuation and fault capture.
  always_comb begin
    state_d      = state_q;
    floor_idx_d  = floor_idx_q;
    step_d       = step_q;
    dir_d        = dir_q;
    door_cnt_d   = door_cnt_q;
    arrive_d     = 1'b0;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    door_move_c  = 1'b0;
    overtravel_c = 1'b0;
    stall_c      = 1'b0;
    at_limit_c   = direction ? (floor_idx_q == FLOOR_TOP) : (floor_idx_q == '0);

    unique case (state_q)
      ST_AT_FLOOR: begin
        if (motion) begin
          // Door counter holds while motion is commanded at a floor.
          if (door_cnt_q != '0) begin
            door_move_c = 1'b1;
          end else if (at_limit_c) begin
            overtravel_c = 1'b1;
          end else begin
            state_d = ST_TRAVEL;
            dir_d   = direction;
            step_d  = '0;
          end
        end else if (door_open) begin
          if (door_cnt_q != DOOR_MAX) door_cnt_d = door_cnt_q + DOOR_W'(1);
        end else begin
          if (door_cnt_q != '0) door_cnt_d = door_cnt_q - DOOR_W'(1);
        end
      end
      ST_TRAVEL: begin
        door_move_c = door_open;
        stall_c     = !(motion && (direction == dir_q));
        // Progress continues only with motion held in the latched direction.
        if (motion && (direction == dir_q)) begin
          if (step_q == STEP_LAST) begin
            state_d     = ST_AT_FLOOR;
            floor_idx_d = dir_q ? (floor_idx_q + FLOOR_W'(1)) : (floor_idx_q - FLOOR_W'(1));
            arrive_d    = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      default: state_d = ST_AT_FLOOR;
    endcase

    // First fault wins; same-cycle priority DOOR_MOVE > OVERTRAVEL > STALL.
    if (!fault_q) begin
      if (door_move_c) begin
        fault_d      = 1'b1;
        fault_code_d = FC_DOOR_MOVE;
      end else if (overtravel_c) begin
        fault_d      = 1'b1;
        fault_code_d = FC_OVERTRAVEL;
      end else if (stall_c) begin
        fault_d      = 1'b1;
        fault_code_d = FC_STALL;
      end
    end

    floor_sense_d     = (state_d == ST_AT_FLOOR) ? (ONEHOT_0 << floor_idx_d) : '0;
    door_closed_d     = (door_cnt_d == '0);
    door_fully_open_d = (door_cnt_d == DOOR_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= ST_AT_FLOOR;
      floor_idx_q       <= FLOOR_INIT;
      step_q            <= '0;
      dir_q             <= 1'b0;
      door_cnt_q        <= '0;
      floor_sense_q     <= ONEHOT_0 << FLOOR_INIT;
      arrive_q          <= 1'b0;
      door_closed_q     <= 1'b1;
      door_fully_open_q <= 1'b0;
      fault_q           <= 1'b0;
      fault_code_q      <= FC_NONE;
    end else begin
      state_q           <= state_d;
      floor_idx_q       <= floor_idx_d;
      step_q            <= step_d;
      dir_q             <= dir_d;
      door_cnt_q        <= door_cnt_d;
      floor_sense_q     <= floor_sense_d;
      arrive_q          <= arrive_d;
      door_closed_q     <= door_closed_d;
      door_fully_open_q <= door_fully_open_d;
      fault_q           <= fault_d;
      fault_code_q      <= fault_code_d;
    end
  end

  assign floor_sense     = floor_sense_q;
  assign floor_idx       = floor_idx_q;
  assign arrive          = arrive_q;
  assign door_closed     = door_closed_q;
  assign door_fully_open = door_fully_open_q;
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;

endmodule

// File: doc/lift_car_model.md
Name: lift_car_model

Overview:
- Synthesizable plant model of the lift car and shaft; the opposite end of the lift controller interface.
- Consumes the controller's direction/motion/door_open commands and produces the floor_sense one-hot the controller observes.
- Models inter-floor travel time and door actuation time, and flags illegal command sequences.
- Used in closed-loop simulation and FPGA demo builds in place of the real shaft sensors.

Parameters:
- N_FLOORS, 8, number of floors (>=2).
- TRAVEL_CYCLES, 16, motion-enabled cycles to move between adjacent floors (>=2).
- DOOR_CYCLES, 4, cycles for the door to go fully closed to fully open, and back (>=1).
- INIT_FLOOR, 0, floor index the car occupies after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- direction  in  1  controller command, 1 = up, 0 = down
- motion  in  1  controller command, 1 = drive car
- door_open  in  1  controller command, 1 = open door
- floor_sense  out  N_FLOORS  one-hot current floor; all zero while between floors
- floor_idx  out  $clog2(N_FLOORS)  index of last floor reached
- arrive  out  1  one-cycle pulse on the cycle the car reaches a floor
- door_closed  out  1  door counter == 0
- door_fully_open  out  1  door counter == DOOR_CYCLES
- fault  out  1  sticky error flag
- fault_code  out  2  first fault: 0 none, 1 DOOR_MOVE, 2 OVERTRAVEL, 3 STALL

Behaviour:
- All outputs are registered.
- Reset values (reset == 0 at a clk edge):
  - state = AT_FLOOR, floor_idx = INIT_FLOOR, floor_sense = 1 << INIT_FLOOR.
  - step = 0, door counter = 0, door_closed = 1, door_fully_open = 0.
  - arrive = 0, fault = 0, fault_code = 0.
- Reset mid-travel or mid-door returns the model to the reset values in one cycle.
- State machine, car:
  - AT_FLOOR: floor_sense = onehot(floor_idx).
    - Departure (motion=1, door_closed=1, not at limit): latch travel_dir = direction, step = 0, next state TRAVEL. floor_sense is 0 from the next cycle.
    - motion=1 with door_closed=0: DOOR_MOVE fault; car stays.
    - motion=1 with up at floor N_FLOORS-1, or down at floor 0: OVERTRAVEL fault; car stays.
  - TRAVEL: floor_sense = 0.
    - Each cycle with motion=1 and direction==travel_dir: if step == TRAVEL_CYCLES-1, floor_idx +/-1, state AT_FLOOR, arrive = 1 next cycle; otherwise step++.
    - motion=0: STALL fault; step holds, car holds. Travel resumes when motion returns.
    - direction != travel_dir with motion=1: STALL fault; step holds.
    - door_open=1: DOOR_MOVE fault; door counter does not move.
- Timing: departure sampled at cycle t gives floor_sense = 0 for cycles t+1 .. t+TRAVEL_CYCLES (plus stalled cycles), and onehot(new floor) with arrive = 1 at t+TRAVEL_CYCLES+1.
- Door counter, which only moves in AT_FLOOR with motion=0:
  - door_open=1: counter increments, saturating at DOOR_CYCLES.
  - door_open=0: counter decrements, saturating at 0.
  - In AT_FLOOR with motion=1, the counter holds.
- Fault logic:
  - fault and fault_code capture the first fault and are cleared only by reset.
  - Later faults never overwrite fault_code.
  - If several faults occur in the same cycle, priority is DOOR_MOVE > OVERTRAVEL > STALL.
  - fault is asserted the cycle after the offending sample.
- floor_idx changes only on arrival and never wraps; the limit checks make underflow and overflow impossible.
- arrive is never asserted in consecutive cycles (TRAVEL_CYCLES >= 2).

Test Plan:
1. Reset with INIT_FLOOR=0, hold 3 cycles, assert motion=1 and direction=1 at cycle 10 -> floor_sense=0 for cycles 11..26; floor_sense=8'b0000_0010, floor_idx=1, arrive=1 at cycle 27; fault=0.
2. At floor 2, door_open=1 for 6 cycles then 0 -> door_fully_open=1 after 4 cycles and stays saturated; door_closed=1 four cycles after release.
3. At floor 2 with door counter=2, assert motion=1 -> fault=1, fault_code=1; floor_sense stays 8'b0000_0100; car does not depart.
4. At floor 7 with direction=1 and motion=1 -> fault_code=2, floor_sense=8'b1000_0000. Separate run at floor 0 with direction=0 -> fault_code=2.
5. Mid-travel from floor 1 up, drop motion for 5 cycles at step 6 -> fault_code=3; arrival at floor 2 is delayed by exactly 5 cycles. Flipping direction mid-travel also gives fault_code=3 with step frozen.
6. Mid-travel, assert door_open and drop motion in the same cycle -> fault_code=1 (priority). A later OVERTRAVEL leaves the code at 1. Pulling reset low mid-travel -> floor_sense = 1 << INIT_FLOOR and fault=0 on the next cycle.
